// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder. A single 1-bit full-adder cell plus a carry
//                flip-flop adds two WIDTH-bit operands LSB-first, one bit per
//                clock. Operands arrive and results leave over valid/ready
//                handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra counter bit so the count never wraps before the last bit.
    localparam int                 CNT_W      = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_sum_next;

    // Handshake outputs decode only from registered state.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_last    = (r_cnt == C_CNT_LAST);

    // The single full-adder cell working on the current LSBs and carry.
    assign w_s = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_c = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);

    // Sum bits enter at the MSB and shift down, so after WIDTH steps the first
    // bit computed sits at bit 0. A 1-bit sum has nothing to shift.
    generate
        if (WIDTH == 1) begin : g_sum_single
            assign w_sum_next = w_s;
        end else begin : g_sum_shift
            assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, then shift one bit per RUN cycle.
    // Result registers are untouched in IDLE/DONE so the last result persists.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_carry <= w_c;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_sum   <= w_sum_next;
                    r_cnt   <= r_cnt + C_CNT_ONE;
                    if (w_last) begin
                        r_cout <= w_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1
//                instances) against an arithmetic reference a+b+cin.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [7:0] a, b, sum;

    logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
    logic [0:0] a1, b1, sum1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    // One full transaction on the 8-bit instance. When noisy, in_valid and the
    // operand inputs are scrambled while the block is busy.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input int hold, input bit noisy);
        logic [8:0] expv;
        logic [7:0] held_sum;
        logic       held_cout;
        int         lat;
        expv = 9'(ta) + 9'(tb_v) + 9'(tc);
        wait_ready;
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (noisy) begin
                in_valid = 1'($urandom);
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
            tick;
            lat++;
            if (!out_valid) check("busy_in_ready", 32'(in_ready), 32'd0);
        end
        check("latency", 32'(lat), 32'd8);
        check("sum", 32'(sum), 32'(expv[7:0]));
        check("cout", 32'(cout), 32'(expv[8]));
        held_sum  = sum;
        held_cout = cout;
        for (int i = 0; i < hold; i++) begin
            if (noisy) begin
                in_valid = 1'($urandom);
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
            tick;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum", 32'(sum), 32'(held_sum));
            check("hold_cout", 32'(cout), 32'(held_cout));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("idle_sum_kept", 32'(sum), 32'(expv[7:0]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] e1;
        int         lat;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
        tick;
        tick;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst1_in_ready", 32'(in_ready1), 32'd1);
        check("rst1_out_valid", 32'(out_valid1), 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        run_op(8'h12, 8'h34, 1'b1, 5, 1'b0);

        // Stray in_valid with a different operand during RUN is ignored.
        wait_ready;
        a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        a = 8'h11; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 2;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
        end
        check("ignore_latency", 32'(lat), 32'd8);
        check("ignore_sum", 32'(sum), 32'h03);
        check("ignore_cout", 32'(cout), 32'd0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // Reset in RUN cycle 3 aborts without a result.
        wait_ready;
        a = 8'hC3; b = 8'h7E; cin = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick; tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        run_op(8'h80, 8'h80, 1'b0, 0, 1'b0);

        // Randomized traffic with scrambled inputs and random backpressure.
        for (int i = 0; i < 25; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        // WIDTH=1: full-adder truth table, back-to-back.
        out_ready1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [2:0] combo;
            int         n;
            combo = 3'(k);
            n = 0;
            while (!in_ready1 && n < 10) begin
                tick;
                n++;
            end
            check("w1_ready", 32'(in_ready1), 32'd1);
            a1 = combo[2]; b1 = combo[1]; cin1 = combo[0]; in_valid1 = 1'b1;
            e1 = 9'(combo[2]) + 9'(combo[1]) + 9'(combo[0]);
            tick;
            in_valid1 = 1'b0;
            lat = 0;
            while (!out_valid1 && lat < 10) begin
                tick;
                lat++;
            end
            check("w1_latency", 32'(lat), 32'd1);
            check("w1_sum", 32'(sum1), 32'(e1[0]));
            check("w1_cout", 32'(cout1), 32'(e1[1]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
